// File: rtl/iodelay_rdy_monitor.sv
// Core-clock monitor for the IDELAYCTRL RDY flag: synchronizes, qualifies,
// counts ready losses and requests recalibration through a req/ack handshake.
module iodelay_rdy_monitor #(
    parameter int sync_stages_p    = 2,
    parameter int settle_cycles_p  = 64,
    parameter int timeout_cycles_p = 4096,
    parameter int drop_cnt_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        rdy_i,
    input  logic                        recal_ack_i,
    output logic                        recal_req_o,
    output logic                        ready_o,
    output logic                        timeout_fault_o,
    output logic [drop_cnt_width_p-1:0] drop_count_o
);

    localparam int cnt_max_lp =
        (settle_cycles_p > timeout_cycles_p) ? settle_cycles_p
                                             : timeout_cycles_p;
    localparam int cnt_w_lp = $clog2(cnt_max_lp + 1);

    localparam logic [cnt_w_lp-1:0] settle_last_lp  =
        cnt_w_lp'(settle_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] timeout_last_lp =
        cnt_w_lp'(timeout_cycles_p - 1);

    localparam logic [1:0] st_wait   = 2'd0;
    localparam logic [1:0] st_settle = 2'd1;
    localparam logic [1:0] st_ready  = 2'd2;
    localparam logic [1:0] st_recal  = 2'd3;

    logic [sync_stages_p-1:0]    sync_q;
    logic [sync_stages_p-1:0]    sync_d;
    logic                        rdy_sync;

    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic [cnt_w_lp-1:0]         cnt_q;
    logic [cnt_w_lp-1:0]         cnt_d;
    logic                        fault_q;
    logic                        fault_d;
    logic [drop_cnt_width_p-1:0] drop_q;
    logic [drop_cnt_width_p-1:0] drop_d;

    // rdy_i is asynchronous; only the last stage is ever looked at
    always_comb begin
        sync_d = {sync_q[sync_stages_p-2:0], rdy_i};
    end

    assign rdy_sync = sync_q[sync_stages_p-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        drop_d  = drop_q;
        unique case (state_q)
            st_wait: begin
                if (rdy_sync) begin
                    state_d = st_settle;
                    cnt_d   = '0;
                end else if (cnt_q == timeout_last_lp) begin
                    state_d = st_recal;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            st_settle: begin
                if (!rdy_sync) begin
                    state_d = st_wait;
                    cnt_d   = '0;
                end else if (cnt_q == settle_last_lp) begin
                    state_d = st_ready;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            st_ready: begin
                if (!rdy_sync) begin
                    state_d = st_recal;
                    cnt_d   = '0;
                    if (~&drop_q) begin
                        drop_d = drop_q + 1'b1;
                    end
                end
            end
            st_recal: begin
                if (recal_ack_i) begin
                    state_d = st_wait;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = st_wait;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q  <= '0;
            state_q <= st_wait;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
        end
    end

    assign ready_o         = (state_q == st_ready);
    assign recal_req_o     = (state_q == st_recal);
    assign timeout_fault_o = fault_q;
    assign drop_count_o    = drop_q;

endmodule
